// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader sits on the slave modport; the byte source and memory sit on master.
interface prog_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wren, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wren, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a big-endian word image from a byte stream into instruction memory and holds the
// CPU in reset until done. Define LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
module prog_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  prog_loader_if.slave  bus,
  output logic          cpu_reset_o,
  output logic          done_o,
  output logic          error_o,
  output logic [12:0]   words_loaded_o
);

  localparam logic [2:0] StCntHi = 3'd0;
  localparam logic [2:0] StCntLo = 3'd1;
  localparam logic [2:0] StDatHi = 3'd2;
  localparam logic [2:0] StDatLo = 3'd3;
  localparam logic [2:0] StChk   = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] StAfterLast = StChk;
`else
  localparam logic [2:0] StAfterLast = StDone;
`endif

  logic [2:0]        state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [7:0]        hi_q, hi_d;
  logic [12:0]       idx_q, idx_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              done_q, error_q, cpu_reset_q;
  logic              accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        acc_q, acc_d;
`endif

  assign bus.in_ready = !reset && (state_q == StCntHi || state_q == StCntLo ||
                                   state_q == StDatHi || state_q == StDatLo ||
                                   state_q == StChk);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    idx_d   = idx_q;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_CHECKSUM_EN
    acc_d   = acc_q;
    if (accept && state_q != StChk) acc_d = acc_q + bus.in_data;
`endif
    if (accept) begin
      case (state_q)
        StCntHi: begin
          count_d = {bus.in_data, 8'h00};
          state_d = StCntLo;
        end
        StCntLo: begin
          count_d = {count_q[15:8], bus.in_data};
          if (32'(count_d) > DEPTH)  state_d = StError;
          else if (count_d == 16'd0) state_d = StAfterLast;
          else                       state_d = StDatHi;
        end
        StDatHi: begin
          hi_d    = bus.in_data;
          state_d = StDatLo;
        end
        StDatLo: begin
          wren_d  = 1'b1;
          addr_d  = ADDR_W'(idx_q);
          data_d  = {hi_q, bus.in_data};
          idx_d   = idx_q + 13'd1;
          // idx_q counts words before this one, so +1 reaching N marks the last word
          state_d = (({3'b000, idx_q} + 16'd1) == count_q) ? StAfterLast : StDatHi;
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: state_d = (bus.in_data == acc_q) ? StDone : StError;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= StCntHi;
      count_q     <= 16'd0;
      hi_q        <= 8'd0;
      idx_q       <= 13'd0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= 16'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      hi_q        <= hi_d;
      idx_q       <= idx_d;
      wren_q      <= wren_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_q      <= (state_d == StDone);
      error_q     <= (state_d == StError);
      cpu_reset_q <= (state_d != StDone);
`ifdef LOADER_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.mem_wren   = wren_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign words_loaded_o = idx_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a stream-position reference model checked every cycle, driven by a
// table of directed streams, a hand-written mid-load reset sequence and random streams.
module tb_prog_loader;

  localparam int Depth = 4096;
`ifdef LOADER_CHECKSUM_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        cpu_reset, done, error;
  logic [12:0] words_loaded;

  always #5 CLOCK_50 = ~CLOCK_50;

  prog_loader_if #(.ADDR_W(12)) bus ();

  prog_loader #(.ADDR_W(12), .DEPTH(Depth)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .bus            (bus),
    .cpu_reset_o    (cpu_reset),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tracks position in the stream rather than any state encoding.
  int          m_pos, m_n, m_sum;
  logic [7:0]  m_hi;
  bit          m_term, m_in_reset;
  bit          exp_wren, exp_done, exp_err;
  int          exp_addr, exp_words;
  logic [15:0] exp_data;
  int          act_writes;
  logic [15:0] last_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_n = 0; m_sum = 0; m_hi = 8'h00; m_term = 0; m_in_reset = 1;
    exp_wren = 0; exp_done = 0; exp_err = 0; exp_addr = 0; exp_words = 0; exp_data = 16'h0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (m_pos == 0) begin
      m_n = int'(b) << 8;
    end else if (m_pos == 1) begin
      m_n = m_n + int'(b);
      if (m_n > Depth) begin
        m_term = 1; exp_err = 1;
      end else if (m_n == 0 && !ChkEn) begin
        m_term = 1; exp_done = 1;
      end
    end else if (m_pos < 2 + 2 * m_n) begin
      int off;
      off = m_pos - 2;
      if (off % 2 == 0) m_hi = b;
      else begin
        exp_wren  = 1;
        exp_addr  = off / 2;
        exp_data  = {m_hi, b};
        exp_words = off / 2 + 1;
        if (m_pos == 1 + 2 * m_n && !ChkEn) begin
          m_term = 1; exp_done = 1;
        end
      end
    end else begin
      m_term = 1;
      if (b == m_sum[7:0]) exp_done = 1;
      else                 exp_err  = 1;
    end
    m_sum = (m_sum + int'(b)) % 256;
    m_pos++;
  endtask

  // One clock cycle: drive inputs, check registered outputs from the previous edge, advance model.
  task automatic step(input bit rst, input bit valid, input logic [7:0] data);
    @(negedge CLOCK_50);
    reset = rst; bus.in_valid = valid; bus.in_data = data;
    #1;
    check("mem_wren", 32'(bus.mem_wren), 32'(exp_wren));
    if (exp_wren || m_in_reset) begin
      check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      check("mem_data", 32'(bus.mem_data), 32'(exp_data));
    end
    check("done", 32'(done), 32'(exp_done));
    check("error", 32'(error), 32'(exp_err));
    check("cpu_reset", 32'(cpu_reset), 32'(!exp_done));
    check("words_loaded", 32'(words_loaded), 32'(exp_words));
    check("in_ready", 32'(bus.in_ready), 32'(!rst && !m_term));
    if (bus.mem_wren === 1'b1) begin
      act_writes++;
      last_data = bus.mem_data;
    end
    if (rst) model_reset();
    else begin
      m_in_reset = 0;
      exp_wren   = 0;
      if (valid && !m_term) model_accept(data);
    end
  endtask

  typedef struct {
    string       name;
    logic [7:0]  bytes[8];
    int          len;
    bit          toggle;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    int          exp_writes;
    logic [15:0] exp_last;
  } case_t;

  case_t cases[5];

  task automatic run_case(input case_t c);
    act_writes = 0;
    step(1, 0, 8'h00);
    step(1, 0, 8'h00);
    for (int i = 0; i < c.len; i++) begin
      if (c.toggle) step(0, 0, 8'hFF);
      step(0, 1, c.bytes[i]);
    end
    // Extra bytes offered after the image must be refused.
    repeat (3) step(0, 1, 8'h5A);
    check({c.name, "/done"}, 32'(done), 32'(c.exp_done));
    check({c.name, "/error"}, 32'(error), 32'(c.exp_err));
    check({c.name, "/cpu_reset"}, 32'(cpu_reset), 32'(!c.exp_done));
    check({c.name, "/words"}, 32'(words_loaded), 32'(c.exp_words));
    check({c.name, "/writes"}, 32'(act_writes), 32'(c.exp_writes));
    check({c.name, "/in_ready"}, 32'(bus.in_ready), 32'd0);
    if (c.exp_writes > 0) check({c.name, "/last_data"}, 32'(last_data), 32'(c.exp_last));
  endtask

  initial begin
    logic [7:0] q[$];
    reset = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    model_reset();
    act_writes = 0; last_data = 16'h0;
    repeat (2) @(posedge CLOCK_50);

    // Modulo-256 sum of 00 02 12 34 AB CD is C0.
    cases[0] = '{"n2_stream", '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00},
                 ChkEn ? 7 : 6, 1'b0, 1'b1, 1'b0, 2, 2, 16'hABCD};
    cases[1] = '{"n2_toggle", '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0, 8'h00},
                 ChkEn ? 7 : 6, 1'b1, 1'b1, 1'b0, 2, 2, 16'hABCD};
    cases[2] = '{"oversize", '{8'h10, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00},
                 6, 1'b0, 1'b0, 1'b1, 0, 0, 16'h0000};
    cases[3] = '{"n0", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                 ChkEn ? 3 : 2, 1'b0, 1'b1, 1'b0, 0, 0, 16'h0000};
    // With checksum the trailing 07 is wrong (sum is 06); without, it is refused as surplus.
    cases[4] = '{"bad_chk", '{8'h00, 8'h01, 8'h00, 8'h05, 8'h07, 8'h00, 8'h00, 8'h00},
                 5, 1'b0, !ChkEn, ChkEn, 1, 1, 16'h0005};

    for (int i = 0; i < 5; i++) run_case(cases[i]);

    // Reset part-way through a load, then a complete one-word image.
    act_writes = 0;
    step(1, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 1, 8'h02);
    step(0, 1, 8'h12);
    step(1, 1, 8'h34);
    step(0, 1, 8'h00);
    step(0, 1, 8'h01);
    step(0, 1, 8'hBE);
    step(0, 1, 8'hEF);
    if (ChkEn) step(0, 1, 8'hAE);
    repeat (2) step(0, 0, 8'h00);
    check("midreset/writes", 32'(act_writes), 32'd1);
    check("midreset/last_data", 32'(last_data), 32'h0000BEEF);
    check("midreset/done", 32'(done), 32'd1);
    check("midreset/words", 32'(words_loaded), 32'd1);

    // Random streams with gaps, bad checksums, oversize counts and occasional mid-load reset.
    for (int it = 0; it < 40; it++) begin
      int n, sum, cut;
      int r;
      r = int'($urandom_range(0, 9));
      n = (r == 9) ? int'($urandom_range(4097, 65535)) : r % 5;
      q.delete();
      q.push_back(8'(n >> 8));
      q.push_back(8'(n));
      for (int k = 0; k < ((n > Depth) ? 2 : 2 * n); k++) q.push_back(8'($urandom));
      sum = 0;
      foreach (q[k]) sum = sum + int'(q[k]);
      if (ChkEn) q.push_back(($urandom_range(0, 3) == 0) ? 8'(sum + 1) : 8'(sum));
      cut = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, q.size())) : -1;
      step(1, 0, 8'h00);
      for (int k = 0; k < q.size(); k++) begin
        while ($urandom_range(0, 3) == 0) step(0, 0, 8'($urandom));
        step(k == cut, 1, q[k]);
      end
      repeat (2) step(0, $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
